// File: rtl/cnn_ctrl_pkg.sv
// rtl/cnn_ctrl_pkg.sv - shared state encoding and default geometry for the CNN window scheduler
package cnn_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SCAN  = 2'd2,
    ST_DRAIN = 2'd3
  } sched_state_e;

  localparam int DEF_N_R    = 28;
  localparam int DEF_N_C    = 28;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 16;

endpackage

// File: rtl/conv_window_scheduler_if.sv
// rtl/conv_window_scheduler_if.sv - pixel load stream, window memory ports and window handshake
interface conv_window_scheduler_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
);
  logic              pix_valid;
  logic [DATA_W-1:0] pix_data;
  logic              pix_ready;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_wadd;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ren;
  logic [ADDR_W-1:0] mem_addr1;
  logic [ADDR_W-1:0] mem_addr2;
  logic              win_valid;
  logic              win_ready;
  logic [ADDR_W-1:0] win_row;
  logic [ADDR_W-1:0] win_col;

  modport master (
    input  pix_valid, pix_data, win_ready,
    output pix_ready, mem_wen, mem_wadd, mem_wdata, mem_ren, mem_addr1, mem_addr2,
           win_valid, win_row, win_col
  );

  modport slave (
    output pix_valid, pix_data, win_ready,
    input  pix_ready, mem_wen, mem_wadd, mem_wdata, mem_ren, mem_addr1, mem_addr2,
           win_valid, win_row, win_col
  );
endinterface

// File: rtl/window_raster_counter.sv
// rtl/window_raster_counter.sv - raster row/col counter over all valid 3x3 window origins
module window_raster_counter #(
  parameter int N_R    = 28,
  parameter int N_C    = 28,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  output logic [ADDR_W-1:0] row_o,
  output logic [ADDR_W-1:0] col_o,
  output logic              last_o
);
  localparam logic [ADDR_W-1:0] ROW_MAX = ADDR_W'(N_R - 3);
  localparam logic [ADDR_W-1:0] COL_MAX = ADDR_W'(N_C - 3);

  logic [ADDR_W-1:0] row_q, row_d, col_q, col_d;

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign last_o = (row_q == ROW_MAX) && (col_q == COL_MAX);

  // Wrapping after the last origin leaves the counter at (0,0) ready for the next frame.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (en_i) begin
      if (col_q == COL_MAX) begin
        col_d = '0;
        row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end
endmodule

// File: rtl/conv_window_scheduler.sv
// rtl/conv_window_scheduler.sv - LOAD/SCAN sequencer for the 3x3 window image memory
// Optional stall_cycles counter enabled by CONV_SCHED_STALL_CNT_EN.
module conv_window_scheduler
  import cnn_ctrl_pkg::*;
#(
  parameter int N_R     = DEF_N_R,
  parameter int N_C     = DEF_N_C,
  parameter int NUM_PIX = N_R * N_C,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic skip_load,
  output logic busy,
  output logic done,
`ifdef CONV_SCHED_STALL_CNT_EN
  output logic [31:0] stall_cycles,
`endif
  conv_window_scheduler_if.master bus
);
  sched_state_e      state_q, state_d;
  logic [ADDR_W-1:0] load_cnt_q, load_cnt_d;
  logic [ADDR_W-1:0] win_row_q, win_row_d, win_col_q, win_col_d;
  logic              win_valid_q, win_valid_d;
  logic              issue, handshake, scan_last;
  logic [ADDR_W-1:0] scan_row, scan_col;

  window_raster_counter #(.N_R(N_R), .N_C(N_C), .ADDR_W(ADDR_W)) u_raster (
    .clk    (clk),
    .rst    (rst),
    .en_i   (issue),
    .row_o  (scan_row),
    .col_o  (scan_col),
    .last_o (scan_last)
  );

  // A new read may only replace the window registers once the held window is gone.
  assign issue     = (state_q == ST_SCAN) && (!win_valid_q || bus.win_ready);
  assign handshake = win_valid_q && bus.win_ready;

  assign bus.mem_ren   = issue;
  assign bus.mem_addr1 = scan_row;
  assign bus.mem_addr2 = scan_col;
  assign bus.win_valid = win_valid_q;
  assign bus.win_row   = win_row_q;
  assign bus.win_col   = win_col_q;
  assign busy          = (state_q != ST_IDLE);

  always_comb begin
    state_d       = state_q;
    load_cnt_d    = load_cnt_q;
    win_valid_d   = win_valid_q;
    win_row_d     = win_row_q;
    win_col_d     = win_col_q;
    done          = 1'b0;
    bus.pix_ready = 1'b0;
    bus.mem_wen   = 1'b0;
    bus.mem_wadd  = load_cnt_q;
    bus.mem_wdata = {DATA_W{1'b0}};

    if (issue) begin
      win_valid_d = 1'b1;
      win_row_d   = scan_row;
      win_col_d   = scan_col;
    end else if (handshake) begin
      win_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = skip_load ? ST_SCAN : ST_LOAD;
      end
      ST_LOAD: begin
        bus.pix_ready = 1'b1;
        bus.mem_wen   = bus.pix_valid;
        bus.mem_wdata = bus.pix_data;
        if (bus.pix_valid) begin
          if (load_cnt_q == ADDR_W'(NUM_PIX - 1)) begin
            load_cnt_d = '0;
            state_d    = ST_SCAN;
          end else begin
            load_cnt_d = load_cnt_q + 1'b1;
          end
        end
      end
      ST_SCAN: begin
        if (issue && scan_last) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (handshake) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      load_cnt_q  <= '0;
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
    end else begin
      state_q     <= state_d;
      load_cnt_q  <= load_cnt_d;
      win_valid_q <= win_valid_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
    end
  end

`ifdef CONV_SCHED_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == ST_IDLE && start) begin
      stall_d = '0;
    end else if ((state_q == ST_SCAN || state_q == ST_DRAIN) && win_valid_q &&
                 !bus.win_ready && stall_q != 32'hFFFF_FFFF) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_conv_window_scheduler.sv
// tb/tb_conv_window_scheduler.sv - directed bench for conv_window_scheduler (4x4 and 28x28 instances)
module tb_conv_window_scheduler;
  logic clk = 1'b0;
  logic rst;
  logic start4, skip4, busy4, done4;
  logic start28, skip28, busy28, done28;
`ifdef CONV_SCHED_STALL_CNT_EN
  logic [31:0] stall4, stall28;
`endif
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  conv_window_scheduler_if #(.ADDR_W(10), .DATA_W(16)) bus4 ();
  conv_window_scheduler_if #(.ADDR_W(10), .DATA_W(16)) bus28 ();

  conv_window_scheduler #(.N_R(4), .N_C(4), .NUM_PIX(16), .ADDR_W(10), .DATA_W(16)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .skip_load(skip4), .busy(busy4), .done(done4),
`ifdef CONV_SCHED_STALL_CNT_EN
    .stall_cycles(stall4),
`endif
    .bus(bus4)
  );

  conv_window_scheduler dut28 (
    .clk(clk), .rst(rst), .start(start28), .skip_load(skip28), .busy(busy28), .done(done28),
`ifdef CONV_SCHED_STALL_CNT_EN
    .stall_cycles(stall28),
`endif
    .bus(bus28)
  );

  typedef struct {
    logic st, sk, wr;
    logic bz, rn;
    int   a1, a2;
    logic wv;
    int   r, c;
    logic dn;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t v(input logic st, sk, wr, bz, rn, input int a1, a2,
                             input logic wv, input int r, c, input logic dn);
    vec_t t;
    t.st = st; t.sk = sk; t.wr = wr; t.bz = bz; t.rn = rn;
    t.a1 = a1; t.a2 = a2; t.wv = wv; t.r = r; t.c = c; t.dn = dn;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Assumes win_ready is held high; checks raster tag order and the done pulse.
  task automatic run_scan(input bit big, input int side, input int abort_at,
                          output int hs, output int cyc);
    bit got;
    logic wv, dn, rn, pr;
    logic [9:0] r, c, a1, a2;
    hs = 0; cyc = 0; got = 0;
    while (!got && cyc < 2000 && !(abort_at != 0 && hs == abort_at)) begin
      #4;
      wv = big ? bus28.win_valid : bus4.win_valid;
      dn = big ? done28 : done4;
      rn = big ? bus28.mem_ren : bus4.mem_ren;
      pr = big ? bus28.pix_ready : bus4.pix_ready;
      r  = big ? bus28.win_row : bus4.win_row;
      c  = big ? bus28.win_col : bus4.win_col;
      a1 = big ? bus28.mem_addr1 : bus4.mem_addr1;
      a2 = big ? bus28.mem_addr2 : bus4.mem_addr2;
      if (cyc == 0) begin
        chk("scan_first_ren", rn, 1);
        chk("scan_first_pix_ready", pr, 0);
        chk("scan_first_addr1", a1, 0);
        chk("scan_first_addr2", a2, 0);
      end
      if (wv) begin
        chk($sformatf("scan_row_w%0d", hs), r, hs / side);
        chk($sformatf("scan_col_w%0d", hs), c, hs % side);
        chk($sformatf("scan_done_w%0d", hs), dn, (hs == side * side - 1));
        hs++;
      end else begin
        chk("scan_done_novalid", dn, 0);
      end
      got = dn;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  initial begin
    int hs, cyc, writes, nwen;
    bit pv;

    tbl[0]  = v(1,1,1, 0,0,0,0, 0,0,0, 0);
    tbl[1]  = v(0,1,1, 1,1,0,0, 0,0,0, 0);
    tbl[2]  = v(0,1,1, 1,1,0,1, 1,0,0, 0);
    tbl[3]  = v(0,1,1, 1,1,1,0, 1,0,1, 0);
    tbl[4]  = v(0,1,1, 1,1,1,1, 1,1,0, 0);
    tbl[5]  = v(0,1,1, 1,0,0,0, 1,1,1, 1);
    tbl[6]  = v(0,1,1, 0,0,0,0, 0,0,0, 0);
    tbl[7]  = v(1,1,1, 0,0,0,0, 0,0,0, 0);
    tbl[8]  = v(0,1,1, 1,1,0,0, 0,0,0, 0);
    tbl[9]  = v(0,1,0, 1,0,0,1, 1,0,0, 0);
    tbl[10] = v(1,1,0, 1,0,0,1, 1,0,0, 0);
    tbl[11] = v(0,1,0, 1,0,0,1, 1,0,0, 0);
    tbl[12] = v(0,1,0, 1,0,0,1, 1,0,0, 0);
    tbl[13] = v(0,1,0, 1,0,0,1, 1,0,0, 0);
    tbl[14] = v(0,1,1, 1,1,0,1, 1,0,0, 0);
    tbl[15] = v(0,1,1, 1,1,1,0, 1,0,1, 0);
    tbl[16] = v(0,1,1, 1,1,1,1, 1,1,0, 0);
    tbl[17] = v(0,1,1, 1,0,0,0, 1,1,1, 1);
    tbl[18] = v(0,1,1, 0,0,0,0, 0,0,0, 0);

    rst = 1'b1;
    start4 = 0; skip4 = 0; start28 = 0; skip28 = 0;
    bus4.pix_valid = 1; bus4.pix_data = 16'hBEEF; bus4.win_ready = 0;
    bus28.pix_valid = 1; bus28.pix_data = 16'hBEEF; bus28.win_ready = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #4;
    chk("rst_busy4", busy4, 0);
    chk("rst_done4", done4, 0);
    chk("rst_pix_ready4", bus4.pix_ready, 0);
    chk("rst_wen4", bus4.mem_wen, 0);
    chk("rst_wadd4", bus4.mem_wadd, 0);
    chk("rst_wdata4", bus4.mem_wdata, 0);
    chk("rst_ren4", bus4.mem_ren, 0);
    chk("rst_addr1_4", bus4.mem_addr1, 0);
    chk("rst_addr2_4", bus4.mem_addr2, 0);
    chk("rst_win_valid4", bus4.win_valid, 0);
    chk("rst_win_row4", bus4.win_row, 0);
    chk("rst_win_col4", bus4.win_col, 0);
    chk("rst_busy28", busy28, 0);
    chk("rst_wen28", bus28.mem_wen, 0);
    chk("rst_win_valid28", bus28.win_valid, 0);
`ifdef CONV_SCHED_STALL_CNT_EN
    chk("rst_stall4", stall4, 0);
`endif
    @(posedge clk); #1;
    bus4.pix_valid = 0; bus28.pix_valid = 0;

    // Two skip_load frames on the 4x4 instance: free-running, then a 5-cycle stall with a stray start.
    for (int i = 0; i < 19; i++) begin
      start4 = tbl[i].st; skip4 = tbl[i].sk; bus4.win_ready = tbl[i].wr;
      #4;
      chk($sformatf("tbl%0d_busy", i), busy4, tbl[i].bz);
      chk($sformatf("tbl%0d_ren", i), bus4.mem_ren, tbl[i].rn);
      chk($sformatf("tbl%0d_addr1", i), bus4.mem_addr1, tbl[i].a1);
      chk($sformatf("tbl%0d_addr2", i), bus4.mem_addr2, tbl[i].a2);
      chk($sformatf("tbl%0d_win_valid", i), bus4.win_valid, tbl[i].wv);
      chk($sformatf("tbl%0d_done", i), done4, tbl[i].dn);
      chk($sformatf("tbl%0d_wen", i), bus4.mem_wen, 0);
      if (tbl[i].wv) begin
        chk($sformatf("tbl%0d_win_row", i), bus4.win_row, tbl[i].r);
        chk($sformatf("tbl%0d_win_col", i), bus4.win_col, tbl[i].c);
      end
      @(posedge clk); #1;
    end
    start4 = 0;
`ifdef CONV_SCHED_STALL_CNT_EN
    chk("stall4_after_frame", stall4, 5);
`endif

    // 4x4 load with pix_valid toggling, then the scan that follows.
    start4 = 1; skip4 = 0; bus4.win_ready = 1;
    @(posedge clk); #1;
    start4 = 0;
    writes = 0; nwen = 0; cyc = 0;
    while (writes < 16 && cyc < 64) begin
      pv = (cyc % 2 == 0);
      bus4.pix_valid = pv;
      bus4.pix_data = 16'h0100 + 16'(cyc);
      #4;
      chk("ld4_pix_ready", bus4.pix_ready, 1);
      chk("ld4_wen", bus4.mem_wen, pv);
      if (bus4.mem_wen) nwen++;
      if (pv) begin
        chk($sformatf("ld4_wadd_%0d", writes), bus4.mem_wadd, writes);
        chk($sformatf("ld4_wdata_%0d", writes), bus4.mem_wdata, 32'h0100 + cyc);
        writes++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus4.pix_valid = 0;
    chk("ld4_wen_count", nwen, 16);
    run_scan(0, 2, 0, hs, cyc);
    chk("f4_windows", hs, 4);
    chk("f4_latency", cyc, 5);

    // Full 28x28 load with pix_valid held high, then a complete scan.
    start28 = 1; skip28 = 0; bus28.win_ready = 1;
    @(posedge clk); #1;
    start28 = 0;
    nwen = 0;
    for (int i = 0; i < 784; i++) begin
      bus28.pix_valid = 1;
      bus28.pix_data = 16'(i * 3 + 7);
      #4;
      if (bus28.mem_wen) nwen++;
      chk($sformatf("ld28_wadd_%0d", i), bus28.mem_wadd, i);
      chk($sformatf("ld28_wdata_%0d", i), bus28.mem_wdata, 32'((i * 3 + 7) & 16'hFFFF));
      @(posedge clk); #1;
    end
    bus28.pix_valid = 0;
    chk("ld28_wen_count", nwen, 784);
    run_scan(1, 26, 0, hs, cyc);
    chk("f28_windows", hs, 676);
    chk("f28_latency", cyc, 677);

    // Reset after window 300 of a resident-image frame, then a fresh full frame.
    start28 = 1; skip28 = 1;
    @(posedge clk); #1;
    start28 = 0;
    run_scan(1, 26, 300, hs, cyc);
    chk("abort_windows", hs, 300);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    #4;
    chk("abort_busy", busy28, 0);
    chk("abort_win_valid", bus28.win_valid, 0);
    chk("abort_done", done28, 0);
    chk("abort_ren", bus28.mem_ren, 0);
    @(posedge clk); #1;
    start28 = 1; skip28 = 1;
    @(posedge clk); #1;
    start28 = 0;
    run_scan(1, 26, 0, hs, cyc);
    chk("refill_windows", hs, 676);
    chk("refill_latency", cyc, 677);
    #4;
    chk("refill_idle_busy", busy28, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/conv_window_scheduler.md
Name: conv_window_scheduler

Overview:
- Sequencer for the 3x3-window image memory in the CNN convolution datapath.
- Two phases per frame:
  - LOAD: accepts a raster pixel stream and drives the memory write port (wen/wadd/wdata).
  - SCAN: steps the window origin (addr1 = row, addr2 = col) over every valid 3x3 position and drives ren.
- Presents each window's nine taps to the downstream MAC stage with a valid/ready handshake, plus row/col tags and a frame-done pulse.

Parameters:
- N_R, 28, image rows.
- N_C, 28, image columns.
- NUM_PIX, 784, pixels per frame; must equal N_R*N_C.
- ADDR_W, 10, memory address width (wadd, addr1, addr2).
- DATA_W, 16, pixel width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin a frame; sampled only in IDLE.
- skip_load  in  1  sampled with start; 1 = go straight to SCAN using resident image.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the last window handshakes.
- pix_valid  in  1  load stream valid.
- pix_data  in  DATA_W  load stream pixel, raster order.
- pix_ready  out  1  high only in LOAD.
- mem_wen  out  1  memory write enable.
- mem_wadd  out  ADDR_W  memory write address.
- mem_wdata  out  DATA_W  memory write data.
- mem_ren  out  1  memory read enable.
- mem_addr1  out  ADDR_W  window origin row.
- mem_addr2  out  ADDR_W  window origin column.
- win_valid  out  1  memory rdata0..8 currently hold a valid window.
- win_ready  in  1  downstream accepts the window.
- win_row  out  ADDR_W  origin row of the presented window.
- win_col  out  ADDR_W  origin column of the presented window.

Behaviour:
- Reset: state = IDLE; all outputs 0; counters 0.
- States:
  - IDLE --start & !skip_load--> LOAD.
  - IDLE --start & skip_load--> SCAN.
  - LOAD --last pixel written--> SCAN.
  - SCAN --last window issued--> DRAIN.
  - DRAIN --final win handshake--> IDLE, with done = 1 in that same cycle.
- LOAD:
  - pix_ready = 1.
  - mem_wen = pix_valid (combinational); mem_wdata = pix_data; mem_wadd = load counter.
  - Counter increments on each accepted pixel.
  - On acceptance at counter = NUM_PIX-1: counter clears and state goes to SCAN on the next edge.
  - Gaps in pix_valid stall the load with no side effects.
- SCAN issue rule:
  - mem_ren = issue = (!win_valid | win_ready) & scan pending.
  - mem_addr1/mem_addr2 = current row/col counters.
  - Column counter runs 0..N_C-3; on wrap it returns to 0 and the row counter increments (0..N_R-3).
  - Windows per frame = (N_R-2)*(N_C-2); 676 by default.
  - The issue at row = N_R-3, col = N_C-3 is the last one; state then goes to DRAIN.
- Output side:
  - Memory read latency is 1 cycle.
  - win_valid is set the cycle after an issue.
  - win_row/win_col are registered copies of the issued addresses, aligned with the data.
  - win_valid clears on handshake (win_valid & win_ready) when there is no simultaneous issue.
  - A simultaneous handshake and issue keeps win_valid = 1 (back-to-back, one window per clock).
  - While win_valid & !win_ready, ren stays low, so the memory rdata registers hold their values.
- Boundary rules:
  - start while busy is ignored.
  - skip_load = 1 performs no writes.
  - win_ready held high gives throughput of 1 window per clk; frame latency = windows + 1 cycles.
  - rst at any time, including mid-LOAD or mid-SCAN, returns to IDLE within 1 cycle. No done pulse is emitted. Partially written memory contents are left as-is.
  - Counters are ADDR_W wide; arithmetic is unsigned; no wrap beyond the stated limits.

Optional Feature:
- Macro: CONV_SCHED_STALL_CNT_EN.
- Enabled:
  - Adds output stall_cycles [31:0] that counts SCAN/DRAIN cycles with win_valid & !win_ready.
  - Clears at frame start and at rst; saturates at 2^32-1.
- Disabled: the port and the counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package (cnn_ctrl_pkg):
  - State enum {IDLE, LOAD, SCAN, DRAIN}.
  - Default N_R/N_C/ADDR_W/DATA_W constants.
- Sub-module window_raster_counter: nested row/col counter with enable, wrap, and a last flag. It is the only natural split.

Test Plan:
- Default params, start with skip_load = 0, 784 pixels streamed with pix_valid always high:
  - mem_wadd steps 0..783 and wen is asserted 784 times.
  - SCAN begins the cycle after the wen at 783.
  - 676 windows arrive and done pulses at the 676th handshake.
  - First tags (0,0); last tags (25,25).
- N_R = N_C = 4, win_ready held high: exactly 4 windows with tags (0,0),(0,1),(1,0),(1,1) on consecutive cycles; done in the same cycle as the 4th handshake.
- win_ready = 0 for 5 cycles mid-scan:
  - win_valid, win_row and win_col stay stable.
  - mem_ren = 0 throughout.
  - No window is lost or duplicated; with CONV_SCHED_STALL_CNT_EN, stall_cycles = 5.
- pix_valid toggling every other cycle: 16 writes to addresses 0..15 for a 4x4 image; no write occurs while pix_valid = 0.
- start pulsed during SCAN: ignored, with no restart and the counters undisturbed.
- rst asserted at window 300 of 676: next cycle state = IDLE, busy = 0, win_valid = 0, done never pulses; a fresh start with skip_load = 1 then produces a full 676-window frame.
